// File: rtl/led_sequencer.sv
// Five-pattern LED sequencer stepped by a programmable prescaler tick.
// Pattern phase and LED register advance together, so LEDR always reflects (state, ph).
module led_sequencer #(
    parameter int LED_W = 18,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             start,
    input  logic             pause,
    input  logic             dir,
    input  logic [DIV_W-1:0] div_max,
    output logic [LED_W-1:0] LEDR,
    output logic [2:0]       state,
    output logic             value,
    output logic             tick
);

    localparam int PH_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(LED_W - 1);
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [LED_W-1:0] LED_S0 = LED_W'(32'h0000_0030);

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [PH_W-1:0]  ph_r;
    logic [PH_W-1:0]  ph_next_s;
    logic [DIV_W-1:0] cnt_r;
    logic             value_r;
    logic [LED_W-1:0] led_r;
    logic [LED_W-1:0] led_next_s;
    logic             tick_s;
    logic             adv_s;
    logic             illegal_s;

    function automatic logic [LED_W-1:0] decode(input logic [2:0] st,
                                                input logic [PH_W-1:0] p,
                                                input logic d);
        logic [LED_W-1:0] ones;
        logic [LED_W-1:0] r;
        ones = '1;
        r    = '0;
        case (st)
            S0: r = LED_S0;
            S1: r = d ? (LED_W'(1'b1) << (PH_LAST - p)) : (LED_W'(1'b1) << p);
            S2: r = '0;
            S3: begin
                for (int i = 0; i < LED_W; i++) begin
                    r[i] = (1'(i % 2) == p[0]);
                end
            end
            S4: r = ones >> (PH_LAST - p);
            default: r = LED_S0;
        endcase
        return r;
    endfunction

    // tick is forced low during reset even though cnt==div_max may already hold
    assign tick_s    = ~reset & ~value_r & (cnt_r == div_max);
    assign adv_s     = tick_s & ~in;
    assign illegal_s = (state_r > S4);

    assign tick  = tick_s;
    assign state = state_r;
    assign value = value_r;
    assign LEDR  = led_r;

    // Prescaler: free-runs while unpaused; wraps naturally if div_max drops below cnt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!value_r) begin
            cnt_r <= (cnt_r == div_max) ? '0 : cnt_r + DIV_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pause flag: start has priority over pause
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_r <= 1'b0;
        end else if (start) begin
            value_r <= 1'b0;
        end else if (pause) begin
            value_r <= 1'b1;
        end else begin
            value_r <= value_r;
        end
    end

    // State register with phase counter and LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S0;
            ph_r    <= '0;
            led_r   <= LED_S0;
        end else begin
            state_r <= state_next_s;
            ph_r    <= ph_next_s;
            led_r   <= led_next_s;
        end
    end

    // Next-state logic; illegal encodings fall back to S0 unconditionally
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S0: state_next_s = adv_s ? (dir ? S4 : S1) : S0;
            S1: state_next_s = adv_s ? (dir ? S0 : S2) : S1;
            S2: state_next_s = adv_s ? (dir ? S1 : S3) : S2;
            S3: state_next_s = adv_s ? (dir ? S2 : S4) : S3;
            S4: state_next_s = adv_s ? (dir ? S3 : S0) : S4;
            default: state_next_s = S0;
        endcase
    end

    // Output logic: phase and LED pattern only move on a tick or illegal-state recovery,
    // which is what makes dir take effect only at step boundaries
    always_comb begin
        ph_next_s  = ph_r;
        led_next_s = led_r;
        if (state_next_s != state_r) begin
            ph_next_s = '0;
        end else if (tick_s) begin
            ph_next_s = (ph_r == PH_LAST) ? '0 : ph_r + PH_W'(1);
        end else begin
            ph_next_s = ph_r;
        end
        if (tick_s || illegal_s) begin
            led_next_s = decode(state_next_s, ph_next_s, dir);
        end else begin
            led_next_s = led_r;
        end
    end

endmodule
